// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the FIFO read-port arbiter.
package fifo_read_arbiter_pkg;

  // Default number of read requesters and burst length.
  localparam int NUM_RD_REQ   = 4;
  localparam int RD_BURST_LEN = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_read_arbiter_rr_priority_pick.sv
// Round-robin priority pick: the first eligible request bit found by
// scanning upward from last_owner+1, wrapping modulo N.
module rr_priority_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_owner,
  input  logic [N-1:0]    excl,
  output logic [N-1:0]    winner,
  output logic [ID_W-1:0] winner_id,
  output logic            found
);

  localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  // Walk the N candidate positions in rotated order; keep the first hit.
  always_comb begin
    winner    = '0;
    winner_id = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      sum = {1'b0, last_owner} + (ID_W+1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      cand = sum[ID_W-1:0];
      if (!found && req[cand] && !excl[cand]) begin
        found     = 1'b1;
        winner_id = cand;
      end
    end
    winner[winner_id] = found;
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares the FIFO read port among NUM_REQ consumers with round-robin burst
// grants; rd_valid is aligned to the 1-cycle synchronous RAM read.
//
// state    | meaning
// ST_IDLE  | no grant held, waiting for any request
// ST_GRANT | gnt owns the read port; reads issue while req & ~f_empty
module fifo_read_arbiter
  import fifo_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_RD_REQ,
  parameter int BURST_LEN = RD_BURST_LEN,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int CNT_W     = 4
) (
  input  logic               rd_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               f_empty,
  output logic               enable_rd,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic [NUM_REQ-1:0] rd_valid,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0]    last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_id;
  logic               pick_found;
  logic               acc;
  logic               rel_full;
  logic               rel_drop;

  // The current owner is excluded so a release hands over to someone else
  // first; in idle gnt_q is zero so nothing is excluded.
  rr_priority_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .excl       (gnt_q),
    .winner     (pick_onehot),
    .winner_id  (pick_id),
    .found      (pick_found)
  );

  assign busy      = (state_q == ST_GRANT);
  assign acc       = busy && req[gnt_id_q] && !f_empty;
  assign rel_full  = acc && (burst_cnt_q == LAST_CNT);
  assign rel_drop  = busy && !req[gnt_id_q];
  assign enable_rd = acc;
  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign rd_valid  = rd_valid_q;

  // Next-state: grant issue, burst counting and release/handover.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    rd_valid_d   = acc ? gnt_q : '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d      = ST_GRANT;
          gnt_d        = pick_onehot;
          gnt_id_d     = pick_id;
          last_owner_d = pick_id;
          burst_cnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (rel_full || rel_drop) begin
          burst_cnt_d = '0;
          if (pick_found) begin
            gnt_d        = pick_onehot;
            gnt_id_d     = pick_id;
            last_owner_d = pick_id;
          end else if (!rel_full) begin
            // Owner withdrew and nobody else wants the port.
            state_d  = ST_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
          // A completed burst with no other contender re-grants the owner.
        end else if (acc) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any in-flight rd_valid immediately.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      burst_cnt_q  <= '0;
      last_owner_q <= ID_W'(NUM_REQ - 1);
      rd_valid_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter: a cycle model of the
// arbitration rules plus directed scenarios with literal expectations.
module tb_fifo_read_arbiter;

  localparam int N  = 4;
  localparam int BL = 4;

  logic         rd_clk = 1'b0;
  logic         reset  = 1'b1;
  logic [N-1:0] req    = '0;
  logic         f_empty = 1'b0;
  logic         enable_rd;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic [N-1:0] rd_valid;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  fifo_read_arbiter #(
    .NUM_REQ   (N),
    .BURST_LEN (BL),
    .ID_W      (2),
    .CNT_W     (4)
  ) dut (
    .rd_clk    (rd_clk),
    .reset     (reset),
    .req       (req),
    .f_empty   (f_empty),
    .enable_rd (enable_rd),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .rd_valid  (rd_valid),
    .busy      (busy)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = -1 means nobody holds the port; rdv = owner whose read is on the bus.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = N - 1;
  int m_rdv   = -1;
  int m_w;
  bit m_en, m_full, m_drop;

  function automatic int pick(input int last, input int excl, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic bit model_en();
    return (m_owner >= 0) && req[m_owner] && !f_empty;
  endfunction

  always @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_cnt = 0; m_last = N - 1; m_rdv = -1;
    end else begin
      m_en  = model_en();
      m_rdv = m_en ? m_owner : -1;
      if (m_owner < 0) begin
        m_w = pick(m_last, -1, req);
        if (m_w >= 0) begin m_owner = m_w; m_last = m_w; m_cnt = 0; end
      end else begin
        m_full = m_en && (m_cnt == BL - 1);
        m_drop = !req[m_owner];
        if (m_full || m_drop) begin
          m_w = pick(m_last, m_owner, req);
          m_cnt = 0;
          if (m_w >= 0) begin m_owner = m_w; m_last = m_w; end
          else if (!m_full) m_owner = -1;
        end else if (m_en) begin
          m_cnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge rd_clk) begin
    check("gnt",       8'(gnt),       (m_owner >= 0) ? 8'(1 << m_owner) : 8'h0);
    check("enable_rd", 8'(enable_rd), 8'(model_en()));
    check("rd_valid",  8'(rd_valid),  (m_rdv >= 0) ? 8'(1 << m_rdv) : 8'h0);
    check("busy",      8'(busy),      8'(m_owner >= 0));
    if (m_owner >= 0) check("gnt_id", 8'(gnt_id), 8'(m_owner));
    check("inv_en_gnt", 8'(enable_rd && (gnt == '0)), 8'h0);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; f_empty = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_gnt",  8'(gnt), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);

    // No requests, FIFO flag toggling: nothing ever issues.
    for (int i = 0; i < 6; i++) begin
      f_empty = ~f_empty;
      step(1);
      check("t6_en",   8'(enable_rd), 8'h0);
      check("t6_gnt",  8'(gnt), 8'h0);
      check("t6_rdv",  8'(rd_valid), 8'h0);
      check("t6_busy", 8'(busy), 8'h0);
    end

    // Reset mid-burst: owner 2 with two reads done.
    do_reset();
    req = 4'b0100;
    step(1);
    step(2);
    check("t1_pre_gnt", 8'(gnt), 8'h04);
    check("t1_pre_en",  8'(enable_rd), 8'h1);
    check("t1_pre_rdv", 8'(rd_valid), 8'h04);
    reset = 1'b1;
    #1;
    check("t1_gnt", 8'(gnt), 8'h0);
    check("t1_en",  8'(enable_rd), 8'h0);
    check("t1_rdv", 8'(rd_valid), 8'h0);
    req = 4'b0011;
    step(1);
    reset = 1'b0;
    step(1);
    check("t1_regnt", 8'(gnt), 8'h01);

    // Single requester: continuous reads across the self re-grant.
    do_reset();
    req = 4'b0001;
    step(1);
    for (int c = 0; c < 2 * BL + 1; c++) begin
      check("t2_en",  8'(enable_rd), 8'h1);
      check("t2_gnt", 8'(gnt), 8'h01);
      if (c > 0) check("t2_rdv", 8'(rd_valid), 8'h01);
      step(1);
    end
    req = 4'b0000;
    step(2);
    check("t2_idle", 8'(gnt), 8'h0);

    // All four requesting: bursts of four in order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    step(1);
    for (int c = 0; c < 4 * BL; c++) begin
      check("t3_gnt", 8'(gnt), 8'(1 << (c / BL)));
      check("t3_en",  8'(enable_rd), 8'h1);
      if (c > 0) check("t3_rdv", 8'(rd_valid), 8'(1 << ((c - 1) / BL)));
      step(1);
    end
    check("t3_wrap_gnt", 8'(gnt), 8'h01);
    check("t3_wrap_rdv", 8'(rd_valid), 8'h08);

    // Owner 1 withdraws after two reads while requester 3 waits.
    do_reset();
    req = 4'b1010;
    step(1);
    check("t4_gnt1", 8'(gnt), 8'h02);
    step(2);
    req = 4'b1000;
    #1;
    check("t4_drop_en",  8'(enable_rd), 8'h0);
    check("t4_drop_rdv", 8'(rd_valid), 8'h02);
    step(1);
    check("t4_gnt3", 8'(gnt), 8'h08);
    check("t4_rdv0", 8'(rd_valid), 8'h0);
    check("t4_en",   8'(enable_rd), 8'h1);

    // FIFO empty for five cycles mid-burst (owner 0, one read done).
    do_reset();
    req = 4'b0101;
    step(1);
    step(1);
    f_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_hold_gnt", 8'(gnt), 8'h01);
      check("t5_hold_en",  8'(enable_rd), 8'h0);
      step(1);
    end
    f_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_rd_en",  8'(enable_rd), 8'h1);
      check("t5_rd_gnt", 8'(gnt), 8'h01);
      step(1);
    end
    check("t5_release", 8'(gnt), 8'h04);

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
